// File: rtl/byte_serial_add32_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : byte_serial_add32_ctrl
//  Description : Sequences a WIDTH-bit add/subtract through an external
//                SLICE_W-bit adder slice, least-significant slice first,
//                rippling the carry through a register between passes.
//  Revision    : 1.0  initial release
// ============================================================================
module byte_serial_add32_ctrl #(
    parameter int WIDTH   = 32,
    parameter int SLICE_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               op_sub,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic               carry_out,
    output logic               overflow,
    output logic               zero,
    output logic [SLICE_W-1:0] slice_a,
    output logic [SLICE_W-1:0] slice_b,
    output logic               slice_cin,
    input  logic [SLICE_W-1:0] slice_sum,
    input  logic               slice_cout
);

    localparam int N_SLICES = WIDTH / SLICE_W;
    localparam int c_IDX_W  = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(N_SLICES - 1);

    // A WIDTH that is not a whole number of slices cannot be sequenced.
    if ((WIDTH % SLICE_W) != 0) begin : g_bad_width
        $error("WIDTH must be an integer multiple of SLICE_W");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_IDX_W-1:0]   r_idx;
    logic [WIDTH-1:0]     r_opa;
    logic [WIDTH-1:0]     r_opb;      // already inverted for subtract
    logic                 r_carry;
    logic [WIDTH-1:0]     r_result;
    logic                 r_carry_out;
    logic                 r_overflow;
    logic                 r_zero;
    logic                 w_accept;
    logic                 w_last;
    logic [WIDTH-1:0]     w_result_asm;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_last   = (r_state == S_RUN) && (r_idx == c_LAST_IDX);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode: RUN holds for exactly N_SLICES passes, DONE for one cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Result as it will look once the current pass is written, used for the zero flag.
    always_comb begin
        w_result_asm = r_result;
        w_result_asm[r_idx*SLICE_W +: SLICE_W] = slice_sum;
    end

    // Operand capture, slice stepping, result assembly and final flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx       <= '0;
            r_opa       <= '0;
            r_opb       <= '0;
            r_carry     <= 1'b0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b0;
        end else if (w_accept) begin
            // Subtract is a + ~b + 1: the +1 enters as the first carry-in.
            r_opa   <= a;
            r_opb   <= op_sub ? ~b : b;
            r_carry <= op_sub;
            r_idx   <= '0;
        end else if (r_state == S_RUN) begin
            r_result[r_idx*SLICE_W +: SLICE_W] <= slice_sum;
            r_carry <= slice_cout;
            r_idx   <= r_idx + 1'b1;
            if (w_last) begin
                r_carry_out <= slice_cout;
                r_overflow  <= (r_opa[WIDTH-1] == r_opb[WIDTH-1]) &&
                               (slice_sum[SLICE_W-1] != r_opa[WIDTH-1]);
                r_zero      <= (w_result_asm == '0);
            end
        end
    end

    // Slice operands come only from registers and are parked at zero outside RUN.
    always_comb begin
        slice_a   = '0;
        slice_b   = '0;
        slice_cin = 1'b0;
        if (r_state == S_RUN) begin
            slice_a   = r_opa[r_idx*SLICE_W +: SLICE_W];
            slice_b   = r_opb[r_idx*SLICE_W +: SLICE_W];
            slice_cin = r_carry;
        end
    end

    assign busy      = (r_state == S_RUN) || (r_state == S_DONE);
    assign done      = (r_state == S_DONE);
    assign result    = r_result;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;
    assign zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_byte_serial_add32_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_byte_serial_add32_ctrl
//  Description : Directed vector bench for byte_serial_add32_ctrl with a
//                behavioural 8-bit adder slice.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_byte_serial_add32_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        op_sub;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        carry_out;
    logic        overflow;
    logic        zero;
    logic [7:0]  slice_a;
    logic [7:0]  slice_b;
    logic        slice_cin;
    logic [7:0]  slice_sum;
    logic        slice_cout;
    logic [8:0]  w_slice_full;

    int checks = 0;
    int errors = 0;

    byte_serial_add32_ctrl #(.WIDTH(32), .SLICE_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op_sub     (op_sub),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .carry_out  (carry_out),
        .overflow   (overflow),
        .zero       (zero),
        .slice_a    (slice_a),
        .slice_b    (slice_b),
        .slice_cin  (slice_cin),
        .slice_sum  (slice_sum),
        .slice_cout (slice_cout)
    );

    // External gate-level slice stand-in.
    assign w_slice_full = {1'b0, slice_a} + {1'b0, slice_b} + {8'd0, slice_cin};
    assign slice_sum    = w_slice_full[7:0];
    assign slice_cout   = w_slice_full[8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sub;
        logic [31:0] opa;
        logic [31:0] opb;
        logic [31:0] exp_res;
        logic        exp_c;
        logic        exp_v;
        logic        exp_z;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive a request across one rising edge (edge T), then scramble the operands.
    task automatic start_op(input logic sub, input logic [31:0] aa, input logic [31:0] bb);
        @(negedge clk);
        op_sub = sub;
        a      = aa;
        b      = bb;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        a      = 32'hDEADBEEF;
        b      = 32'hCAFEF00D;
        op_sub = ~sub;
    endtask

    // Count cycles after edge T (cycle T+1 = 1) until done, bounded.
    task automatic wait_done(input int c0, output int cyc);
        cyc = c0;
        do begin
            @(negedge clk);
            cyc++;
            if (!done && cyc < 5) chk("busy_in_run", {31'd0, busy}, 32'd1);
        end while (!done && cyc < 14);
    endtask

    task automatic chk_final(input string tag, input vec_t v, input int cyc);
        chk({tag, "_latency"}, cyc, 5);
        chk({tag, "_done"},    {31'd0, done}, 32'd1);
        chk({tag, "_busy"},    {31'd0, busy}, 32'd1);
        chk({tag, "_result"},  result, v.exp_res);
        chk({tag, "_carry"},   {31'd0, carry_out}, {31'd0, v.exp_c});
        chk({tag, "_ovf"},     {31'd0, overflow},  {31'd0, v.exp_v});
        chk({tag, "_zero"},    {31'd0, zero},      {31'd0, v.exp_z});
        chk({tag, "_slice0"},  {23'd0, slice_a, slice_cin}, 32'd0);
        @(negedge clk);
        chk({tag, "_idle_done"}, {30'd0, done, busy}, 32'd0);
        chk({tag, "_hold"},      result, v.exp_res);
    endtask

    initial begin
        int   cyc;
        int   seen;
        vec_t v;

        vecs[0] = '{1'b0, 32'h000000FF, 32'h00000001, 32'h00000100, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 32'h00000007, 32'h00000007, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1, 1'b1};

        rst = 1'b1; start = 1'b0; op_sub = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("rst_outputs", {26'd0, busy, done, carry_out, overflow, zero, slice_cin}, 32'd0);
        chk("rst_result",  result, 32'd0);
        chk("rst_slice",   {16'd0, slice_a, slice_b}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Table-driven vectors.
        for (int i = 0; i < 8; i++) begin
            v = vecs[i];
            start_op(v.sub, v.opa, v.opb);
            wait_done(0, cyc);
            chk_final($sformatf("vec%0d", i), v, cyc);
        end

        // Slice operands per pass, carry ripples into the idx1 pass.
        start_op(1'b0, 32'h000000FF, 32'h00000001);
        @(negedge clk);
        chk("pass0_slice", {15'd0, slice_a, slice_b, slice_cin}, {15'd0, 8'hFF, 8'h01, 1'b0});
        @(negedge clk);
        chk("pass1_slice", {15'd0, slice_a, slice_b, slice_cin}, {15'd0, 8'h00, 8'h00, 1'b1});
        wait_done(2, cyc);
        chk_final("seq_ripple", vecs[0], cyc);

        // Subtract path presents inverted B and carry-in 1 on the first pass.
        start_op(1'b1, 32'h00000005, 32'h00000007);
        @(negedge clk);
        chk("sub_pass0", {15'd0, slice_a, slice_b, slice_cin}, {15'd0, 8'h05, 8'hF8, 1'b1});
        wait_done(1, cyc);
        chk_final("seq_sub", vecs[3], cyc);

        // Start while busy is ignored; start in the IDLE cycle after DONE is accepted.
        start_op(1'b0, 32'h12345678, 32'h11111111);
        @(negedge clk);                 // cycle 1
        @(negedge clk);                 // cycle 2
        a = 32'h00000001; b = 32'h00000001; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(2, cyc);
        chk("busy_start_latency", cyc, 5);
        chk("busy_start_result", result, 32'h23456789);
        @(negedge clk);                 // cycle 6, IDLE
        chk("idle_after_done", {31'd0, busy}, 32'd0);
        a = 32'h00000010; b = 32'h00000020; op_sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(6, cyc);
        chk("b2b_latency", cyc, 11);
        chk("b2b_result",  result, 32'h00000030);
        @(negedge clk);

        // Reset in the middle of an operation aborts it with no done pulse.
        start_op(1'b0, 32'h12345678, 32'h00000001);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy",   {31'd0, busy}, 32'd0);
        chk("abort_result", result, 32'd0);
        chk("abort_slice",  {15'd0, slice_a, slice_b, slice_cin}, 32'd0);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        seen = 0;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (done || busy) seen = 1;
        end
        chk("abort_no_done", seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the bench never hangs.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
